// File: rtl/ultrasonic_ranger_ctrl.sv
// ultrasonic_ranger_ctrl
// Sequencer for an HC-SR04-style ultrasonic ranger. It issues the trigger pulse,
// times the echo width in clock cycles, and enforces the echo timeout and the
// inter-shot holdoff. It produces one result (dist_valid or timeout) per shot.
//
// Build option: define RANGER_AVG_EN to add the dist_avg output, which is a
// running average of the last four valid distances.
module ultrasonic_ranger_ctrl #(
  parameter int unsigned CNT_W          = 22,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned PERIOD_CYCLES  = 3000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             echo_in,
  output logic             trig_out,
  output logic             busy,
  output logic             dist_valid,
  output logic [CNT_W-1:0] dist_cycles,
  output logic             timeout
`ifdef RANGER_AVG_EN
  ,
  output logic [CNT_W-1:0] dist_avg
`endif
);

  // Terminal counts. Each phase counter starts at 0 in its first cycle.
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TrigLast   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] WaitLast   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WidthLast  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } state_e;

  state_e           state;
  logic [CNT_W-1:0] phase_cnt;   // trig length, echo wait, or echo width
  logic [CNT_W-1:0] period_cnt;  // cycles since the current trig rose
  logic [CNT_W-1:0] period_next;
  logic             period_done;

  logic echo_meta;
  logic echo_s;
  logic echo_prev;
  logic echo_rise;

  // Saturating increment. A counter that hits all-ones stays there rather than
  // wrapping back to a small value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CntOne;
  endfunction

  // Two-flop synchroniser for the asynchronous echo, plus one delayed copy for
  // edge detection. echo_prev tracks continuously, so an echo that is already
  // high when WAIT_RISE is entered does not count as a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
      echo_prev <= 1'b0;
    end else begin
      echo_meta <= echo_in;
      echo_s    <= echo_meta;
      echo_prev <= echo_s;
    end
  end

  assign echo_rise   = echo_s & ~echo_prev;
  assign period_next = sat_inc(period_cnt);
  // The compare uses the value the counter holds once IDLE is reached. The IDLE
  // cycle is therefore the last cycle of the period, and in periodic mode the
  // next trig rises exactly PERIOD_CYCLES after the previous one.
  assign period_done = (period_next >= PeriodLast);

  // Shot sequencer. The counters and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      phase_cnt   <= '0;
      period_cnt  <= '0;
      trig_out    <= 1'b0;
      busy        <= 1'b0;
      dist_valid  <= 1'b0;
      dist_cycles <= '0;
      timeout     <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      period_cnt <= period_next;

      unique case (state)
        StIdle: begin
          // start and enable share one request path; start is only seen here,
          // so a start that arrives while busy is dropped.
          if (start || enable) begin
            state      <= StTrig;
            trig_out   <= 1'b1;
            busy       <= 1'b1;
            phase_cnt  <= '0;
            period_cnt <= '0;
          end
        end

        StTrig: begin
          if (phase_cnt >= TrigLast) begin
            state     <= StWaitRise;
            trig_out  <= 1'b0;
            phase_cnt <= '0;
          end else begin
            phase_cnt <= sat_inc(phase_cnt);
          end
        end

        StWaitRise: begin
          if (echo_rise) begin
            // The rising sample is itself the first high cycle of the echo.
            state     <= StMeasure;
            phase_cnt <= CntOne;
          end else if (phase_cnt >= WaitLast) begin
            state   <= StHoldoff;
            timeout <= 1'b1;
          end else begin
            phase_cnt <= sat_inc(phase_cnt);
          end
        end

        StMeasure: begin
          if (!echo_s) begin
            state       <= StHoldoff;
            dist_cycles <= phase_cnt;
            dist_valid  <= 1'b1;
          end else if (phase_cnt >= WidthLast) begin
            // This high sample brings the width to TIMEOUT_CYCLES.
            state   <= StHoldoff;
            timeout <= 1'b1;
          end else begin
            phase_cnt <= sat_inc(phase_cnt);
          end
        end

        StHoldoff: begin
          // Wait for the sensor to release echo and for the shot period to expire.
          if (period_done && !echo_s) begin
            state <= StIdle;
            busy  <= 1'b0;
          end
        end

        default: begin
          state    <= StIdle;
          trig_out <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef RANGER_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [CNT_W+1:0] hist_sum;

  // Four-deep history of valid distances. The newest sample enters at index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        hist[i] <= '0;
      end
    end else if (dist_valid) begin
      hist[0] <= dist_cycles;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
    end
  end

  // The sum is two bits wider than a sample so that four samples cannot overflow.
  always_comb begin
    hist_sum = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
  end

  assign dist_avg = hist_sum[CNT_W+1:2];
`endif

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Self-checking bench for ultrasonic_ranger_ctrl (TRIG=4, TIMEOUT=100, PERIOD=200).
// Echo shots are described by (delay after trig fall, width). Each shot is
// checked against a shot-level reference model.
`timescale 1ns/1ps
module tb_ultrasonic_ranger_ctrl;
  localparam int CNT_W = 22;
  localparam int TRIG  = 4;
  localparam int TMO   = 100;
  localparam int PER   = 200;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic             echo_in;
  logic             trig_out;
  logic             busy;
  logic             dist_valid;
  logic [CNT_W-1:0] dist_cycles;
  logic             timeout;
`ifdef RANGER_AVG_EN
  logic [CNT_W-1:0] dist_avg;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise   = 0;
  int last_avg    = 0;
  int model_dist  = 0;   // last valid distance the model expects on dist_cycles
  int hist[4];           // model of the averaging history, newest first

  always #5 clk = ~clk;

  ultrasonic_ranger_ctrl #(
    .CNT_W          (CNT_W),
    .TRIG_CYCLES    (TRIG),
    .TIMEOUT_CYCLES (TMO),
    .PERIOD_CYCLES  (PER)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .start       (start),
    .echo_in     (echo_in),
    .trig_out    (trig_out),
    .busy        (busy),
    .dist_valid  (dist_valid),
    .dist_cycles (dist_cycles),
    .timeout     (timeout)
`ifdef RANGER_AVG_EN
    ,
    .dist_avg    (dist_avg)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    model_dist = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
  endtask

  // Runs one complete shot and checks it against the model.
  // delay and width are in cycles after trig falls (width 0 means no echo).
  // start_at and drop_en_at are loop indices at which start is pulsed or
  // enable is dropped (-1 means never).
  task automatic do_shot(input bit kick, input int delay, input int width, input int start_at,
                         input int drop_en_at, input bit chk_spacing);
    int t, tlen, dv_n, to_n, to_k, busy_off, exp_off, exp_to_k;
    bit exp_dv, avg_due;
    logic [CNT_W-1:0] dv_val;
    dv_n = 0; to_n = 0; to_k = -1; busy_off = -1; avg_due = 0; dv_val = '0;
    if (kick) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    t = 0;
    while (trig_out !== 1'b1 && t < 2 * PER) begin
      tick();
      t++;
    end
    vectors++;
    if (trig_out !== 1'b1) begin
      miscompares++;
      $display("FAIL trig_rise: trig_out=%b after %0d cycles, required 1", trig_out, t);
      return;
    end
    if (chk_spacing) begin
      vectors++;
      if (cyc - last_rise !== PER) begin
        miscompares++;
        $display("FAIL trig_spacing: got %0d cycles, required %0d", cyc - last_rise, PER);
      end
    end
    last_rise = cyc;
    tlen = 0;
    while (trig_out === 1'b1 && tlen < 50) begin
      tlen++;
      tick();
    end
    vectors++;
    if (tlen !== TRIG) begin
      miscompares++;
      $display("FAIL trig_len: got %0d, required %0d", tlen, TRIG);
    end
    // k counts loop iterations; k+1 is the number of edges since trig fell.
    for (int k = 0; k < 1000 && busy_off < 0; k++) begin
      echo_in = (k >= delay && k < delay + width);
      if (k == start_at) start = 1'b1;
      if (k == drop_en_at) enable = 1'b0;
      tick();
      start = 1'b0;
`ifdef RANGER_AVG_EN
      if (avg_due) begin
        avg_due = 0;
        last_avg = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
        vectors++;
        if (dist_avg !== CNT_W'(last_avg)) begin
          miscompares++;
          $display("FAIL dist_avg: got %0d, required %0d", dist_avg, last_avg);
        end
      end
`endif
      if (dist_valid === 1'b1 && timeout === 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL exclusive: dist_valid and timeout both 1, required not both");
      end
      if (dist_valid === 1'b1) begin
        dv_n++;
        dv_val = dist_cycles;
        hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = width;
        avg_due = 1;
      end
      if (timeout === 1'b1) begin
        to_n++;
        to_k = k + 1;
      end
      if (busy === 1'b0) busy_off = k + 1 + TRIG;  // edges since trig rose
    end
    echo_in = 1'b0;

    // Reference: an echo narrower than TIMEOUT gives its width; otherwise timeout.
    exp_dv = (width > 0 && width < TMO);
    vectors++;
    if (dv_n !== (exp_dv ? 1 : 0)) begin
      miscompares++;
      $display("FAIL dv_count: got %0d, required %0d (w=%0d)", dv_n, exp_dv ? 1 : 0, width);
    end
    if (exp_dv) begin
      model_dist = width;
      vectors++;
      if (dv_val !== CNT_W'(width)) begin
        miscompares++;
        $display("FAIL dv_value: got %0d, required %0d", dv_val, width);
      end
    end
    vectors++;
    if (to_n !== (exp_dv ? 0 : 1)) begin
      miscompares++;
      $display("FAIL to_count: got %0d, required %0d (w=%0d)", to_n, exp_dv ? 0 : 1, width);
    end
    if (!exp_dv) begin
      // No echo: TMO cycles after trig fall. Long echo: the 100th high sample,
      // which is 2 sync cycles + 1 edge-detect cycle after echo_in rose, +99.
      exp_to_k = (width == 0) ? TMO : delay + 3 + (TMO - 1);
      vectors++;
      if (to_k !== exp_to_k) begin
        miscompares++;
        $display("FAIL to_time: got %0d, required %0d", to_k, exp_to_k);
      end
    end
    // busy drops when PER-1 edges have passed since trig rose (the IDLE cycle
    // completes the period). A long echo instead holds busy until the
    // synchronised echo is seen low.
    exp_off = PER - 1;
    if (width >= TMO && TRIG + delay + width + 3 > exp_off) exp_off = TRIG + delay + width + 3;
    vectors++;
    if (busy_off !== exp_off) begin
      miscompares++;
      $display("FAIL busy_len: got %0d, required %0d (d=%0d w=%0d)", busy_off, exp_off, delay, width);
    end
    vectors++;
    if (dist_cycles !== CNT_W'(model_dist)) begin
      miscompares++;
      $display("FAIL dist_hold: got %0d, required %0d", dist_cycles, model_dist);
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    int act;
    act = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (trig_out !== 1'b0 || busy !== 1'b0) act++;
    end
    vectors++;
    if (act !== 0) begin
      miscompares++;
      $display("FAIL %s: %0d active cycles, required 0", name, act);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0; start = 1'b0; echo_in = 1'b0;
    apply_reset(3);
    vectors += 5;
    if (trig_out !== 1'b0)    begin miscompares++; $display("FAIL rst_trig: got %b, required 0", trig_out); end
    if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (dist_valid !== 1'b0)  begin miscompares++; $display("FAIL rst_dv: got %b, required 0", dist_valid); end
    if (timeout !== 1'b0)     begin miscompares++; $display("FAIL rst_to: got %b, required 0", timeout); end
    if (dist_cycles !== '0)   begin miscompares++; $display("FAIL rst_dist: got %0d, required 0", dist_cycles); end
`ifdef RANGER_AVG_EN
    vectors++;
    if (dist_avg !== '0) begin miscompares++; $display("FAIL rst_avg: got %0d, required 0", dist_avg); end
`endif
  endtask

  task automatic test_single_shot();
    do_shot(1'b1, 10, 37, -1, -1, 1'b0);
  endtask

  task automatic test_no_echo();
    do_shot(1'b1, 0, 0, -1, -1, 1'b0);
  endtask

  task automatic test_long_echo();
    do_shot(1'b1, 10, 150, -1, -1, 1'b0);
    do_shot(1'b1, 60, 190, -1, -1, 1'b0);
    do_shot(1'b1, 5, TMO - 1, -1, -1, 1'b0);
    do_shot(1'b1, 5, TMO, -1, -1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    do_shot(1'b1, 20, 30, 50, -1, 1'b0);
    check_quiet("start_dropped", 30);
  endtask

  task automatic test_periodic();
    enable = 1'b1;
    do_shot(1'b0, 15, 20, -1, -1, 1'b0);
    for (int i = 0; i < 4; i++) do_shot(1'b0, 15, 20, (i == 1) ? 40 : -1, -1, 1'b1);
    do_shot(1'b0, 15, 20, -1, 30, 1'b1);
    check_quiet("enable_drop", 250);
  endtask

  task automatic test_random();
    int d, w, r;
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(0, 80);
      r = $urandom_range(0, 9);
      if (r == 0)      w = 0;
      else if (r < 3)  w = $urandom_range(TMO, 180);
      else             w = $urandom_range(1, TMO - 1);
      do_shot(1'b1, d, w, -1, -1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_measure();
    int t;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (trig_out !== 1'b0 && t < 20) begin tick(); t++; end
    echo_in = 1'b1;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    vectors += 5;
    if (trig_out !== 1'b0)   begin miscompares++; $display("FAIL mid_trig: got %b, required 0", trig_out); end
    if (busy !== 1'b0)       begin miscompares++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (dist_valid !== 1'b0) begin miscompares++; $display("FAIL mid_dv: got %b, required 0", dist_valid); end
    if (timeout !== 1'b0)    begin miscompares++; $display("FAIL mid_to: got %b, required 0", timeout); end
    if (dist_cycles !== '0)  begin miscompares++; $display("FAIL mid_dist: got %0d, required 0", dist_cycles); end
    reset = 1'b0;
    echo_in = 1'b0;
    model_dist = 0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    repeat (3) tick();
    do_shot(1'b1, 10, 37, -1, -1, 1'b0);
  endtask

`ifdef RANGER_AVG_EN
  task automatic test_avg();
    int widths[4];
    int exp_avg[4];
    widths  = '{10, 20, 30, 40};
    exp_avg = '{2, 7, 15, 25};
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      do_shot(1'b1, 5, widths[i], -1, -1, 1'b0);
      vectors++;
      if (dist_avg !== CNT_W'(exp_avg[i])) begin
        miscompares++;
        $display("FAIL avg_seq%0d: got %0d, required %0d", i, dist_avg, exp_avg[i]);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; echo_in = 1'b0;
    for (int i = 0; i < 4; i++) hist[i] = 0;
    test_reset();
    test_single_shot();
    test_no_echo();
    test_long_echo();
    test_start_while_busy();
    test_periodic();
    test_random();
    test_reset_mid_measure();
`ifdef RANGER_AVG_EN
    test_avg();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
